// File: rtl/gb_timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// gb_timer_ctrl_if
// Register-bus and interrupt bundle of the DMG timer controller.
//   tick_en  : one-clk_in-cycle pulse per T-cycle (requester -> timer)
//   addr     : register select 0=DIV 1=TIMA 2=TMA 3=TAC (requester -> timer)
//   wr_en    : write strobe, honoured only with tick_en (requester -> timer)
//   wr_data  : write data (requester -> timer)
//   rd_data  : combinational read of the selected register (timer -> requester)
//   irq      : single-cycle timer interrupt request (timer -> requester)
// master = CPU/bus side, slave = timer side.
// ----------------------------------------------------------------------------
interface gb_timer_ctrl_if;
   logic       tick_en;
   logic [1:0] addr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       irq;

   modport master (
      output tick_en, addr, wr_en, wr_data,
      input  rd_data, irq
   );

   modport slave (
      input  tick_en, addr, wr_en, wr_data,
      output rd_data, irq
   );
endinterface

// File: rtl/gb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// gb_timer_ctrl
// DMG-compatible timer: DIV/TIMA/TMA/TAC at 0xFF04-0xFF07. A free-running
// system counter advances once per T-cycle; TIMA increments on falling edges
// of the TAC-selected counter tap (gated by TAC enable). A TIMA overflow reads
// 00 for a short delay, then reloads from TMA and pulses irq.
// Ports:
//   clk_in   : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : gb_timer_ctrl_if.slave (tick_en, addr, wr_en, wr_data,
//              rd_data, irq)
// Parameter:
//   CNT_W    : system counter width, at least 10 (tap bit 9 must exist)
// ----------------------------------------------------------------------------
module gb_timer_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic           clk_in,
   input  logic           reset_n,
   gb_timer_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,  // TIMA counts, writes land directly
      ST_DELAY  = 2'd1,  // overflowed, TIMA reads 00, reload pending
      ST_RELOAD = 2'd2   // just reloaded, TIMA writes ignored, TMA writes mirror
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       tima_q, tima_d;
   logic [7:0]       tma_q, tma_d;
   logic [2:0]       tac_q, tac_d;
   logic [1:0]       ctr_q, ctr_d;   // shared DELAY/RELOAD tick counter
   logic             sig_q, sig_d;   // last gated tap value
   logic             irq_q, irq_d;

   logic wr_div, wr_tima, wr_tma, wr_tac;
   logic tap_bit, sig_new, inc;

   assign wr_div  = bus.wr_en & (bus.addr == 2'd0);
   assign wr_tima = bus.wr_en & (bus.addr == 2'd1);
   assign wr_tma  = bus.wr_en & (bus.addr == 2'd2);
   assign wr_tac  = bus.wr_en & (bus.addr == 2'd3);

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples the pre-edge values of all the others.
         state_q <= ST_NORMAL;
         cnt_q   <= '0;
         tima_q  <= 8'h00;
         tma_q   <= 8'h00;
         tac_q   <= 3'd0;
         ctr_q   <= 2'd0;
         sig_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tima_q  <= tima_d;
         tma_q   <= tma_d;
         tac_q   <= tac_d;
         ctr_q   <= ctr_d;
         sig_q   <= sig_d;
         irq_q   <= irq_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      tima_d  = tima_q;
      tma_d   = tma_q;
      tac_d   = tac_q;
      ctr_d   = ctr_q;
      sig_d   = sig_q;
      irq_d   = 1'b0;
      tap_bit = 1'b0;
      sig_new = 1'b0;
      inc     = 1'b0;

      if (bus.tick_en) begin
         cnt_d = wr_div ? '0 : cnt_q + CNT_W'(1);
         if (wr_tac) tac_d = bus.wr_data[2:0];
         if (wr_tma) tma_d = bus.wr_data;

         // The tap is taken from the post-write counter and TAC, so clearing
         // DIV or retuning TAC while the tap is high yields a falling edge
         // (the DMG glitch increments) in the same tick.
         case (tac_d[1:0])
            2'd0:    tap_bit = cnt_d[9];
            2'd1:    tap_bit = cnt_d[3];
            2'd2:    tap_bit = cnt_d[5];
            default: tap_bit = cnt_d[7];
         endcase
         sig_new = tac_d[2] & tap_bit;
         sig_d   = sig_new;
         inc     = sig_q & ~sig_new;

         case (state_q)
            ST_NORMAL: begin
               if (wr_tima) begin
                  tima_d = bus.wr_data;
               end else if (inc) begin
                  if (tima_q == 8'hFF) begin
                     tima_d  = 8'h00;
                     state_d = ST_DELAY;
                     ctr_d   = 2'd3;
                  end else begin
                     tima_d = tima_q + 8'd1;
                  end
               end
            end

            ST_DELAY: begin
               if (ctr_q == 2'd0) begin
                  // Reload tick: a same-tick TMA write is already in tma_d.
                  tima_d  = tma_d;
                  irq_d   = 1'b1;
                  state_d = ST_RELOAD;
                  ctr_d   = 2'd3;
               end else if (wr_tima) begin
                  tima_d  = bus.wr_data;
                  state_d = ST_NORMAL;
               end else begin
                  ctr_d = ctr_q - 2'd1;
                  if (inc) tima_d = tima_q + 8'd1;
               end
            end

            ST_RELOAD: begin
               ctr_d = ctr_q - 2'd1;
               if (ctr_q == 2'd1) state_d = ST_NORMAL;
               if (wr_tma) begin
                  tima_d = bus.wr_data;
               end else if (inc) begin
                  if (tima_q == 8'hFF) begin
                     tima_d  = 8'h00;
                     state_d = ST_DELAY;
                     ctr_d   = 2'd3;
                  end else begin
                     tima_d = tima_q + 8'd1;
                  end
               end
            end

            default: state_d = ST_NORMAL;
         endcase
      end
   end

   // Outputs
   always_comb begin
      case (bus.addr)
         2'd0:    bus.rd_data = 8'(cnt_q >> 8);
         2'd1:    bus.rd_data = tima_q;
         2'd2:    bus.rd_data = tma_q;
         default: bus.rd_data = {5'b11111, tac_q};
      endcase
   end

   assign bus.irq = irq_q;

endmodule

// File: tb/tb_gb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gb_timer_ctrl
// Directed stimulus with hand-computed expectations. Register reads and
// expected interrupts are queued by the stimulus; a monitor on the falling
// clock edge pops and compares whenever a read is presented or irq is high.
// ----------------------------------------------------------------------------
module tb_gb_timer_ctrl;

   localparam logic [1:0] A_DIV  = 2'd0;
   localparam logic [1:0] A_TIMA = 2'd1;
   localparam logic [1:0] A_TMA  = 2'd2;
   localparam logic [1:0] A_TAC  = 2'd3;

   logic clk = 1'b0;
   logic reset_n;

   gb_timer_ctrl_if bus ();

   gb_timer_ctrl #(.CNT_W(16)) dut (
      .clk_in  (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string      name;
      logic [1:0] addr;
      logic [7:0] exp;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   int unsigned irq_q[$];
   logic        chk_req = 1'b0;

   rd_exp_t     mon_e;
   int unsigned mon_c;

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (chk_req) begin
         n_cmp++;
         if (rd_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: read presented with no expectation queued");
         end else begin
            mon_e = rd_q.pop_front();
            if (bus.rd_data !== mon_e.exp) begin
               n_err++;
               $display("FAIL %s: rd_data=%02h expected %02h (addr %0d)",
                        mon_e.name, bus.rd_data, mon_e.exp, mon_e.addr);
            end
         end
      end
      if (bus.irq !== 1'b0) begin
         n_cmp++;
         if (irq_q.size() == 0) begin
            n_err++;
            $display("FAIL irq_unexpected: irq=%b at cycle %0d, expected no irq", bus.irq, cyc);
         end else begin
            mon_c = irq_q.pop_front();
            if (cyc != mon_c) begin
               n_err++;
               $display("FAIL irq_timing: irq at cycle %0d expected at cycle %0d", cyc, mon_c);
            end
         end
      end
   end

   task automatic check(input string name, input logic [1:0] a, input logic [7:0] e);
      rd_exp_t it;
      it.name  = name;
      it.addr  = a;
      it.exp   = e;
      bus.addr = a;
      rd_q.push_back(it);
      chk_req  = 1'b1;
      @(negedge clk);
      #1 chk_req = 1'b0;
   endtask

   task automatic wr_tick(input logic [1:0] a, input logic [7:0] d);
      bus.tick_en = 1'b1;
      bus.wr_en   = 1'b1;
      bus.addr    = a;
      bus.wr_data = d;
      @(posedge clk);
      #1;
      bus.tick_en = 1'b0;
      bus.wr_en   = 1'b0;
   endtask

   task automatic run(input int n);
      if (n > 0) begin
         bus.tick_en = 1'b1;
         bus.wr_en   = 1'b0;
         repeat (n) @(posedge clk);
         #1 bus.tick_en = 1'b0;
      end
   endtask

   // irq expected in the cycle following the d-th upcoming clock edge
   task automatic expect_irq(input int unsigned d);
      irq_q.push_back(cyc + d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.tick_en = 1'b0;
      bus.wr_en   = 1'b0;
      bus.addr    = A_DIV;
      bus.wr_data = 8'h00;
      reset_n     = 1'b1;
      #1 reset_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n  = 1'b1;

      // Reset values
      check("rst_div",  A_DIV,  8'h00);
      check("rst_tima", A_TIMA, 8'h00);
      check("rst_tma",  A_TMA,  8'h00);
      check("rst_tac",  A_TAC,  8'hF8);

      // DIV: count, wrap, clear with arbitrary data
      wr_tick(A_DIV, 8'h00);
      run(256);   check("div_256",   A_DIV, 8'h01);
      run(65279); check("div_ffff",  A_DIV, 8'hFF);
      run(1);     check("div_wrap",  A_DIV, 8'h00);
      run(512);   check("div_512",   A_DIV, 8'h02);
      wr_tick(A_DIV, 8'h7A);
      check("div_clear", A_DIV, 8'h00);

      // TAC=05 overflow, delay and reload (sys_cnt=0 after the DIV write)
      wr_tick(A_TMA,  8'hA0);
      wr_tick(A_TIMA, 8'hFE);
      wr_tick(A_TAC,  8'h05);
      check("tac_read", A_TAC, 8'hFD);
      check("tma_read", A_TMA, 8'hA0);
      wr_tick(A_DIV, 8'h00);
      run(15); check("tima_t15", A_TIMA, 8'hFE);
      run(1);  check("tima_t16", A_TIMA, 8'hFF);
      run(15); check("tima_t31", A_TIMA, 8'hFF);
      run(1);  check("ovf_t32",  A_TIMA, 8'h00);
      for (int i = 33; i <= 35; i++) begin
         run(1);
         check($sformatf("delay_t%0d", i), A_TIMA, 8'h00);
      end
      expect_irq(1);
      run(1); check("reload_t36", A_TIMA, 8'hA0);
      run(3);                                   // sys_cnt=39, back to NORMAL

      // TAC=04: tap bit 9, first increment at tick 1024
      wr_tick(A_TAC,  8'h04);
      wr_tick(A_TIMA, 8'h10);
      wr_tick(A_DIV,  8'h00);
      run(1023); check("tac4_t1023", A_TIMA, 8'h10);
      run(1);    check("tac4_t1024", A_TIMA, 8'h11);

      // Glitch increments: DIV write and TAC disable while tap bit is 1
      wr_tick(A_TAC, 8'h05);
      wr_tick(A_DIV, 8'h00);
      run(8);                 check("glitch_pre",  A_TIMA, 8'h11);
      wr_tick(A_DIV, 8'h00);  check("glitch_div",  A_TIMA, 8'h12);
      run(8);                 check("glitch_pre2", A_TIMA, 8'h12);
      wr_tick(A_TAC, 8'h01);  check("glitch_tac",  A_TIMA, 8'h13);
      check("tac_read2", A_TAC, 8'hF9);

      // Cancel: TIMA write at t+2 aborts the reload, no irq
      wr_tick(A_DIV,  8'h00);
      wr_tick(A_TAC,  8'h05);
      wr_tick(A_TIMA, 8'hFF);                   // sys_cnt=2
      run(14); check("cancel_ovf", A_TIMA, 8'h00);
      run(1);
      wr_tick(A_TIMA, 8'h55);
      check("cancel_wr", A_TIMA, 8'h55);
      run(6);  check("cancel_hold", A_TIMA, 8'h55);   // sys_cnt=24

      // Reload window: TIMA write ignored
      wr_tick(A_TIMA, 8'hFF);                   // sys_cnt=25
      run(7);  check("rw1_ovf", A_TIMA, 8'h00);
      expect_irq(4);
      run(4);  check("rw1_reload", A_TIMA, 8'hA0);
      wr_tick(A_TIMA, 8'h11);
      check("rw1_tima_ign", A_TIMA, 8'hA0);
      run(3);                                   // sys_cnt=40

      // Reload window: TMA write mirrors into TIMA
      wr_tick(A_TIMA, 8'hFF);                   // sys_cnt=41
      run(7);
      expect_irq(4);
      run(4);  check("rw2_reload", A_TIMA, 8'hA0);
      wr_tick(A_TMA, 8'h33);
      check("rw2_tima", A_TIMA, 8'h33);
      check("rw2_tma",  A_TMA,  8'h33);
      run(3);                                   // sys_cnt=56

      // Reset at t+2 aborts a pending reload, no irq
      wr_tick(A_TIMA, 8'hFF);                   // sys_cnt=57
      run(7);  check("rst_ovf", A_TIMA, 8'h00);
      run(1);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check("mrst_div",  A_DIV,  8'h00);
      check("mrst_tima", A_TIMA, 8'h00);
      check("mrst_tma",  A_TMA,  8'h00);
      check("mrst_tac",  A_TAC,  8'hF8);
      run(8);  check("mrst_after", A_TIMA, 8'h00);

      // Drain: anything still queued was never observed
      repeat (4) @(posedge clk);
      #1;
      while (irq_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL irq_missing: no irq seen, expected at cycle %0d", irq_q.pop_front());
      end
      while (rd_q.size() != 0) begin
         mon_e = rd_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: read never sampled, expected %02h", mon_e.name, mon_e.exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
